// File: rtl/pipe_result_collector.sv
// rtl/pipe_result_collector.sv - captures pipelined results into a FWFT FIFO
//
// Purpose: tracks operand launches through a LATENCY-deep token pipe and,
// when a token reaches the tap, samples the circuit output res into a small
// first-word-fall-through FIFO. Results arriving while the FIFO is full
// (and not being drained that edge) are dropped and counted.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand set launched into the pipelined circuit this cycle
//   res        pipelined circuit output
//   clr        synchronous clear of overflow / drop_cnt only
//   out_data   FIFO head entry (held while empty)
//   out_valid  out_data holds a captured result
//   out_ready  consumer accepts out_data
//   count      FIFO occupancy, 0..DEPTH
//   overflow   sticky: at least one result was dropped
//   drop_cnt   saturating count of dropped results
module pipe_result_collector #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 3,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           res,
  input  logic                       clr,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [LATENCY-1:0] tok_q, tok_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CW-1:0]      cnt_after_pop;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];

  logic push, pop, full, push_ok, drop;

  // Token pipe: in_valid sampled at edge k sits in stage LATENCY-1 during
  // the cycle after edge k+LATENCY-1, so the push lands on edge k+LATENCY.
  generate
    if (LATENCY == 1) begin : g_tok1
      assign tok_d = in_valid;
    end else begin : g_tokn
      assign tok_d = {tok_q[LATENCY-2:0], in_valid};
    end
  endgenerate

  assign push    = tok_q[LATENCY-1];
  assign full    = (count_q == CW'(DEPTH));
  assign pop     = (count_q != '0) && out_ready;
  // A pop frees the slot the push needs, so full+push+pop is not a drop.
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    out_data_d    = out_data_q;
    overflow_d    = overflow_q;
    drop_cnt_d    = drop_cnt_q;
    cnt_after_pop = count_q - CW'(pop);

    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = cnt_after_pop + CW'(push_ok);

    // out_data is registered: precompute next head so there is no
    // combinational path from res to the output. Empty holds last value.
    if (count_d != '0) begin
      if (cnt_after_pop == '0) begin
        out_data_d = res;
      end else begin
        out_data_d = mem_q[rd_ptr_d];
      end
    end

    // clr first, then a same-cycle drop overrides it.
    if (clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_d != 8'hFF) drop_cnt_d = drop_cnt_d + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_data_q <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      tok_q      <= tok_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      out_data_q <= out_data_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset: push_ok is low whenever the token pipe is cleared.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= res;
  end

  assign out_data  = out_data_q;
  assign out_valid = (count_q != '0);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_pipe_result_collector.sv
// tb/tb_pipe_result_collector.sv - self-checking bench for pipe_result_collector
module tb_pipe_result_collector;

  localparam int WIDTH   = 4;
  localparam int LATENCY = 3;
  localparam int DEPTH   = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] res;
  logic             clr;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       count;
  logic             overflow;
  logic [7:0]       drop_cnt;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  logic [WIDTH-1:0] mq[$];
  int               due[$];
  int               edge_n = 0;
  logic [WIDTH-1:0] m_head;
  logic             m_ovf;
  int               m_drop;

  pipe_result_collector #(.WIDTH(WIDTH), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .res(res), .clr(clr),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    due.delete();
    m_head = '0;
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  // One rising edge of the reference behaviour: a launch at edge k yields a
  // push of res at edge k+LATENCY; pops happen before the room check.
  task automatic model_edge();
    bit push, pop, drop;
    edge_n++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    pop  = (mq.size() != 0) && out_ready;
    push = 0;
    drop = 0;
    if (due.size() != 0 && due[0] == edge_n) begin
      push = 1;
      due.delete(0);
    end
    if (pop) mq.delete(0);
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(res);
      else drop = 1;
    end
    if (clr) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    if (drop) begin
      m_ovf = 1'b1;
      if (m_drop < 255) m_drop++;
    end
    if (in_valid) due.push_back(edge_n + LATENCY);
    if (mq.size() != 0) m_head = mq[0];
  endtask

  task automatic compare(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
    chk({tag, ".count"},     32'(count),     32'(mq.size()));
    chk({tag, ".out_data"},  32'(out_data),  32'(m_head));
    chk({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    chk({tag, ".drop_cnt"},  32'(drop_cnt),  32'(m_drop));
  endtask

  // Called just after a falling edge; drives inputs, takes one rising edge,
  // samples at the next falling edge.
  task automatic step(input string tag, input logic iv, input logic [WIDTH-1:0] r,
                      input logic ordy, input logic c);
    in_valid  = iv;
    res       = r;
    out_ready = ordy;
    clr       = c;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare(tag);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; res = '0; clr = 1'b0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    compare("reset");
    // inputs active during reset must have no effect
    step("in_reset", 1'b1, 4'h5, 1'b1, 1'b1);
    rst_n = 1'b1;
    step("idle", 1'b0, 4'h0, 1'b0, 1'b0);

    // single launch, result 9 three edges later
    step("single", 1'b1, 4'h0, 1'b0, 1'b0);
    step("single", 1'b0, 4'h0, 1'b0, 1'b0);
    step("single", 1'b0, 4'h0, 1'b0, 1'b0);
    chk("single.no_early", 32'(out_valid), 32'd0);
    step("single", 1'b0, 4'h9, 1'b0, 1'b0);
    chk("single.data", 32'(out_data), 32'd9);
    chk("single.count", 32'(count), 32'd1);
    step("single_pop", 1'b0, 4'h0, 1'b1, 1'b0);
    chk("single_pop.count", 32'(count), 32'd0);
    chk("single_pop.hold", 32'(out_data), 32'd9);

    // four back-to-back launches, results 1..4, then drain in order
    for (int i = 0; i < 7; i++)
      step("fill4", logic'(i < 4), (i >= 3) ? 4'(i - 2) : 4'h0, 1'b0, 1'b0);
    chk("fill4.count", 32'(count), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      chk("drain4.head", 32'(out_data), 32'(i));
      step("drain4", 1'b0, 4'h0, 1'b1, 1'b0);
    end
    chk("drain4.empty", 32'(count), 32'd0);

    // six launches into a 4-deep FIFO: 5 and 6 dropped
    for (int i = 0; i < 9; i++)
      step("ovf", logic'(i < 6), (i >= 3) ? 4'(i - 2) : 4'h0, 1'b0, 1'b0);
    chk("ovf.flag", 32'(overflow), 32'd1);
    chk("ovf.drops", 32'(drop_cnt), 32'd2);
    chk("ovf.head", 32'(out_data), 32'd1);

    // full FIFO, push and pop on the same edge
    step("fullpp", 1'b1, 4'h0, 1'b0, 1'b0);
    step("fullpp", 1'b0, 4'h0, 1'b0, 1'b0);
    step("fullpp", 1'b0, 4'h0, 1'b0, 1'b0);
    step("fullpp", 1'b0, 4'h7, 1'b1, 1'b0);
    chk("fullpp.head", 32'(out_data), 32'd2);
    chk("fullpp.count", 32'(count), 32'd4);
    chk("fullpp.drops", 32'(drop_cnt), 32'd2);

    // saturate drop counter, then clear statistics
    step("clr0", 1'b0, 4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 306; i++)
      step("sat", logic'(i < 303), 4'($urandom), 1'b0, 1'b0);
    chk("sat.drops", 32'(drop_cnt), 32'd255);
    chk("sat.flag", 32'(overflow), 32'd1);
    step("clr", 1'b0, 4'h0, 1'b0, 1'b1);
    chk("clr.drops", 32'(drop_cnt), 32'd0);
    chk("clr.count", 32'(count), 32'd4);
    chk("clr.head", 32'(out_data), 32'd2);
    // clr together with a drop: drop wins
    step("clrdrop", 1'b1, 4'h0, 1'b0, 1'b0);
    step("clrdrop", 1'b0, 4'h0, 1'b0, 1'b0);
    step("clrdrop", 1'b0, 4'h0, 1'b0, 1'b0);
    step("clrdrop", 1'b0, 4'hA, 1'b0, 1'b1);
    chk("clrdrop.drops", 32'(drop_cnt), 32'd1);
    for (int i = 0; i < 5; i++) step("drain_sat", 1'b0, 4'h0, 1'b1, 1'b0);

    // reset with two tokens in flight
    step("rst_inflight", 1'b1, 4'h3, 1'b0, 1'b0);
    step("rst_inflight", 1'b1, 4'h4, 1'b0, 1'b0);
    step("rst_inflight", 1'b0, 4'h5, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst.count", 32'(count), 32'd0);
    chk("arst.valid", 32'(out_valid), 32'd0);
    chk("arst.data", 32'(out_data), 32'd0);
    chk("arst.drops", 32'(drop_cnt), 32'd0);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step("post_rst", 1'b0, 4'hF, 1'b0, 1'b0);
    chk("post_rst.count", 32'(count), 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 500; i++)
      step("rand", logic'($urandom_range(0, 1)), 4'($urandom),
           logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 19) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
